// File: rtl/game_sequencer.sv
// Turn-based connect-four move controller: accepts column requests, drives the board store's
// drop/write port and walks the combinational read port for a win or draw. Optional: MOVE_TIMEOUT_EN.
module game_sequencer #(
  parameter int INIT_CYCLES    = 72,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       move_valid,
  input  logic [2:0] move_col,
  output logic       move_ready,
  output logic       move_rejected,
  output logic       brd_enable,
  output logic [2:0] brd_row,
  output logic [2:0] brd_col,
  output logic [1:0] brd_data_in,
  output logic       brd_write,
  input  logic       brd_drop_allowed,
  input  logic [3:0] brd_row_to_drop,
  input  logic [1:0] brd_data_out,
  output logic [1:0] current_player,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [2:0] o_dbg_state
);

  // Handshake: a move transfers on a clk edge where move_valid and move_ready are both high;
  // move_ready is high only in IDLE and move_valid is ignored everywhere else.
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_DROP, S_CHECK, S_DONE} state_t;

  localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  state_t            r_state, w_state_nxt;
  logic [INIT_W-1:0] r_init_cnt, w_init_cnt_nxt;
  logic [2:0]        r_col, w_col_nxt;
  logic [2:0]        r_row, w_row_nxt;
  logic [6:0]        r_move_cnt, w_move_cnt_nxt;
  logic [1:0]        r_player, w_player_nxt;
  logic [1:0]        r_winner, w_winner_nxt;
  logic              r_game_over, w_game_over_nxt;
  logic [1:0]        r_dir, w_dir_nxt;
  logic              r_side, w_side_nxt;
  logic [1:0]        r_step, w_step_nxt;
  logic [2:0]        r_run, w_run_nxt;
  logic              r_stop, w_stop_nxt;
`ifdef MOVE_TIMEOUT_EN
  logic [31:0]       r_idle_cnt, w_idle_cnt_nxt;
`endif

  logic signed [4:0] w_dr, w_dc, w_k, w_prow, w_pcol;
  logic              w_on_board, w_hit, w_drop_ok;
  logic [2:0]        w_run_sum;

  // Probe address: side 0 walks +k along (dr,dc), side 1 walks -k.
  always_comb begin
    w_dr = 5'sd1;
    w_dc = 5'sd0;
    case (r_dir)
      2'd0:    begin w_dr = 5'sd0; w_dc = 5'sd1;  end
      2'd1:    begin w_dr = 5'sd1; w_dc = 5'sd0;  end
      2'd2:    begin w_dr = 5'sd1; w_dc = 5'sd1;  end
      default: begin w_dr = 5'sd1; w_dc = -5'sd1; end
    endcase
    w_k    = r_side ? -$signed({3'b000, r_step}) : $signed({3'b000, r_step});
    w_prow = $signed({2'b00, r_row}) + w_k * w_dr;
    w_pcol = $signed({2'b00, r_col}) + w_k * w_dc;
  end

  assign w_on_board = (w_prow[4:3] == 2'b00) && (w_pcol[4:3] == 2'b00);
  // Once a side sees a mismatch it keeps probing but stops counting, so a side is always 3 cycles.
  assign w_hit      = w_on_board && !r_stop && (brd_data_out == r_player);
  assign w_run_sum  = r_run + {2'b00, w_hit};
  // A landing row of 8 means the column is full even if the store claims otherwise.
  assign w_drop_ok  = brd_drop_allowed && !brd_row_to_drop[3];

  always_comb begin
    w_state_nxt     = r_state;
    w_init_cnt_nxt  = r_init_cnt;
    w_col_nxt       = r_col;
    w_row_nxt       = r_row;
    w_move_cnt_nxt  = r_move_cnt;
    w_player_nxt    = r_player;
    w_winner_nxt    = r_winner;
    w_game_over_nxt = r_game_over;
    w_dir_nxt       = r_dir;
    w_side_nxt      = r_side;
    w_step_nxt      = r_step;
    w_run_nxt       = r_run;
    w_stop_nxt      = r_stop;
`ifdef MOVE_TIMEOUT_EN
    w_idle_cnt_nxt  = 32'd0;
`endif
    move_ready    = 1'b0;
    move_rejected = 1'b0;
    brd_enable    = 1'b0;
    brd_row       = 3'd0;
    brd_col       = 3'd0;
    brd_data_in   = 2'b00;
    brd_write     = 1'b0;

    case (r_state)
      S_INIT: begin
        w_init_cnt_nxt = r_init_cnt + 1'b1;
        if (r_init_cnt == INIT_W'(INIT_CYCLES - 1)) w_state_nxt = S_IDLE;
      end

      S_IDLE: begin
        move_ready = 1'b1;
        if (move_valid) begin
          w_col_nxt   = move_col;
          w_state_nxt = S_DROP;
        end
`ifdef MOVE_TIMEOUT_EN
        else if (r_idle_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
          w_winner_nxt    = r_player ^ 2'b11;
          w_game_over_nxt = 1'b1;
          w_state_nxt     = S_DONE;
        end else begin
          w_idle_cnt_nxt = r_idle_cnt + 32'd1;
        end
`endif
      end

      S_DROP: begin
        brd_enable  = 1'b1;
        brd_col     = r_col;
        brd_data_in = r_player;
        if (w_drop_ok) begin
          brd_write      = 1'b1;
          w_row_nxt      = brd_row_to_drop[2:0];
          w_move_cnt_nxt = r_move_cnt + 7'd1;
          w_dir_nxt      = 2'd0;
          w_side_nxt     = 1'b0;
          w_step_nxt     = 2'd1;
          w_run_nxt      = 3'd0;
          w_stop_nxt     = 1'b0;
          w_state_nxt    = S_CHECK;
        end else begin
          move_rejected = 1'b1;
          w_state_nxt   = S_IDLE;
        end
      end

      S_CHECK: begin
        brd_enable = 1'b1;
        brd_row    = w_on_board ? w_prow[2:0] : 3'd0;
        brd_col    = w_on_board ? w_pcol[2:0] : 3'd0;
        if (r_step == 2'd3) begin
          if (!r_side) begin
            w_side_nxt = 1'b1;
            w_step_nxt = 2'd1;
            w_stop_nxt = 1'b0;
            w_run_nxt  = w_run_sum;
          end else if (w_run_sum >= 3'd3) begin
            w_winner_nxt    = r_player;
            w_game_over_nxt = 1'b1;
            w_state_nxt     = S_DONE;
          end else if (r_dir == 2'd3) begin
            if (r_move_cnt == 7'd64) begin
              w_winner_nxt    = 2'b11;
              w_game_over_nxt = 1'b1;
              w_state_nxt     = S_DONE;
            end else begin
              w_player_nxt = r_player ^ 2'b11;
              w_state_nxt  = S_IDLE;
            end
          end else begin
            w_dir_nxt  = r_dir + 2'd1;
            w_side_nxt = 1'b0;
            w_step_nxt = 2'd1;
            w_run_nxt  = 3'd0;
            w_stop_nxt = 1'b0;
          end
        end else begin
          w_step_nxt = r_step + 2'd1;
          w_run_nxt  = w_run_sum;
          w_stop_nxt = r_stop | ~w_hit;
        end
      end

      default: ;  // S_DONE holds until reset
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_INIT;
      r_init_cnt  <= '0;
      r_col       <= 3'd0;
      r_row       <= 3'd0;
      r_move_cnt  <= 7'd0;
      r_player    <= 2'b01;
      r_winner    <= 2'b00;
      r_game_over <= 1'b0;
      r_dir       <= 2'd0;
      r_side      <= 1'b0;
      r_step      <= 2'd1;
      r_run       <= 3'd0;
      r_stop      <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
      r_idle_cnt  <= 32'd0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_init_cnt  <= w_init_cnt_nxt;
      r_col       <= w_col_nxt;
      r_row       <= w_row_nxt;
      r_move_cnt  <= w_move_cnt_nxt;
      r_player    <= w_player_nxt;
      r_winner    <= w_winner_nxt;
      r_game_over <= w_game_over_nxt;
      r_dir       <= w_dir_nxt;
      r_side      <= w_side_nxt;
      r_step      <= w_step_nxt;
      r_run       <= w_run_nxt;
      r_stop      <= w_stop_nxt;
`ifdef MOVE_TIMEOUT_EN
      r_idle_cnt  <= w_idle_cnt_nxt;
`endif
    end
  end

  assign current_player = r_player;
  assign game_over      = r_game_over;
  assign winner         = r_winner;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: board-store model, rule-level game reference, write scoreboard.
module tb_game_sequencer;

  localparam int INIT_CYCLES    = 72;
  localparam int TIMEOUT_CYCLES = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       move_valid = 1'b0;
  logic [2:0] move_col = 3'd0;
  logic       move_ready, move_rejected;
  logic       brd_enable, brd_write;
  logic [2:0] brd_row, brd_col;
  logic [1:0] brd_data_in;
  logic       brd_drop_allowed;
  logic [3:0] brd_row_to_drop;
  logic [1:0] brd_data_out;
  logic [1:0] current_player, winner;
  logic       game_over;
  logic [2:0] dbg_state;

  int total = 0;
  int bad   = 0;

  game_sequencer #(.INIT_CYCLES(INIT_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .move_valid(move_valid), .move_col(move_col),
    .move_ready(move_ready), .move_rejected(move_rejected),
    .brd_enable(brd_enable), .brd_row(brd_row), .brd_col(brd_col),
    .brd_data_in(brd_data_in), .brd_write(brd_write),
    .brd_drop_allowed(brd_drop_allowed), .brd_row_to_drop(brd_row_to_drop),
    .brd_data_out(brd_data_out),
    .current_player(current_player), .game_over(game_over), .winner(winner),
    .o_dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // board store model: drop into landing row, combinational read port
  logic [1:0] st_board [8][8];
  int         st_h [8];

  assign brd_drop_allowed = (st_h[brd_col] < 8);
  assign brd_row_to_drop  = 4'(st_h[brd_col]);
  assign brd_data_out     = st_board[brd_row][brd_col];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 8; c++) begin
        st_h[c] <= 0;
        for (int r = 0; r < 8; r++) st_board[r][c] <= 2'b00;
      end
    end else if (brd_enable && brd_write && st_h[brd_col] < 8) begin
      st_board[st_h[brd_col]][brd_col] <= brd_data_in;
      st_h[brd_col] <= st_h[brd_col] + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: expected {col, piece} for every board write
  logic [4:0] exp_q[$];

  always @(negedge clk) begin
    if (rst_n && brd_write) begin
      chk("write_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) chk("write_col_data", 32'({brd_enable, brd_col, brd_data_in}),
                                32'({1'b1, exp_q.pop_front()}));
    end
  end

  // game reference model
  logic [1:0] ref_board [8][8];
  int         ref_h [8];
  logic [1:0] ref_player, ref_winner;
  logic       ref_over;
  int         ref_moves;

  function automatic int line_len(input int r, input int c, input int d, input logic [1:0] p);
    int n, rr, cc, dr, dc;
    dr = (d == 0) ? 0 : 1;
    dc = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
    n = 1;
    for (int s = -1; s <= 1; s += 2) begin
      rr = r + s * dr;
      cc = c + s * dc;
      while (rr >= 0 && rr < 8 && cc >= 0 && cc < 8 && ref_board[rr][cc] == p) begin
        n++;
        rr += s * dr;
        cc += s * dc;
      end
    end
    return n;
  endfunction

  // driver tasks
  task automatic wait_ready();
    int n = 0;
    while (!move_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(move_ready), 32'd1);
  endtask

  task automatic do_reset(input bit init_chk);
    int early = 0;
    rst_n = 1'b0;
    move_valid = 1'b0;
    move_col = 3'd0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(move_ready), 32'd0);
    chk("rst_rejected", 32'(move_rejected), 32'd0);
    chk("rst_enable", 32'(brd_enable), 32'd0);
    chk("rst_write", 32'(brd_write), 32'd0);
    chk("rst_addr_data", 32'({brd_row, brd_col, brd_data_in}), 32'd0);
    chk("rst_player", 32'(current_player), 32'd1);
    chk("rst_game_over", 32'(game_over), 32'd0);
    chk("rst_winner", 32'(winner), 32'd0);
    for (int c = 0; c < 8; c++) begin
      ref_h[c] = 0;
      for (int r = 0; r < 8; r++) ref_board[r][c] = 2'b00;
    end
    ref_player = 2'b01;
    ref_winner = 2'b00;
    ref_over = 1'b0;
    ref_moves = 0;
    exp_q.delete();
    if (init_chk) begin
      move_valid = 1'b1;
      move_col = 3'd0;
    end
    rst_n = 1'b1;
    if (init_chk) begin
      for (int i = 1; i < INIT_CYCLES; i++) begin
        @(negedge clk);
        if (move_ready) early++;
      end
      chk("init_ready_low_cycles", 32'(early), 32'd0);
      @(negedge clk);
      chk("init_ready_rise", 32'(move_ready), 32'd1);
    end else begin
      wait_ready();
    end
  endtask

  task automatic play_move(input int col);
    logic [1:0] p;
    logic       full, win;
    int         r, exp_cycles, ncyc;
    wait_ready();
    p = ref_player;
    full = (ref_h[col] == 8);
    if (!full) exp_q.push_back({3'(col), p});
    move_col = 3'(col);
    move_valid = 1'b1;
    @(negedge clk);
    move_valid = 1'b0;
    chk("drop_rejected", 32'(move_rejected), 32'(full));
    chk("drop_enable", 32'(brd_enable), 32'd1);
    if (full) begin
      @(negedge clk);
      chk("reject_pulse_end", 32'(move_rejected), 32'd0);
      chk("reject_ready", 32'(move_ready), 32'd1);
      chk("reject_player", 32'(current_player), 32'(p));
      return;
    end
    r = ref_h[col];
    ref_board[r][col] = p;
    ref_h[col]++;
    ref_moves++;
    win = 1'b0;
    exp_cycles = 24;
    for (int d = 0; d < 4; d++) begin
      if (!win && line_len(r, col, d, p) >= 4) begin
        win = 1'b1;
        exp_cycles = 6 * (d + 1);
      end
    end
    ncyc = 0;
    @(negedge clk);
    while (brd_enable && ncyc < 40) begin
      ncyc++;
      @(negedge clk);
    end
    chk("check_cycles", 32'(ncyc), 32'(exp_cycles));
    if (win) begin
      ref_over = 1'b1;
      ref_winner = p;
    end else if (ref_moves == 64) begin
      ref_over = 1'b1;
      ref_winner = 2'b11;
    end else begin
      ref_player = p ^ 2'b11;
    end
    chk("move_winner", 32'(winner), 32'(ref_winner));
    chk("move_game_over", 32'(game_over), 32'(ref_over));
    chk("move_player", 32'(current_player), 32'(ref_player));
    chk("move_ready_after", 32'(move_ready), 32'(!ref_over));
    chk("move_writes_done", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic play_list(input int cols[$]);
    foreach (cols[i]) play_move(cols[i]);
  endtask

  task automatic poke_after_over(input logic [1:0] exp_w);
    move_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      move_col = 3'($urandom_range(0, 7));
      @(negedge clk);
    end
    move_valid = 1'b0;
    chk("over_ready", 32'(move_ready), 32'd0);
    chk("over_enable", 32'(brd_enable), 32'd0);
    chk("over_winner", 32'(winner), 32'(exp_w));
    chk("over_flag", 32'(game_over), 32'd1);
  endtask

  // directed and random steps
  initial begin
    int draw_seq[$];
    int n;

    do_reset(1'b1);
    play_list('{0, 1, 0, 1, 0, 1, 0});
    chk("vert_winner", 32'(winner), 32'd1);
    chk("vert_player", 32'(current_player), 32'd1);
    poke_after_over(2'b01);

    do_reset(1'b0);
    play_list('{0, 0, 1, 1, 2, 2, 3});
    chk("horiz_winner", 32'(winner), 32'd1);

    do_reset(1'b0);
    play_list('{3, 3, 3, 3, 3, 3, 3, 3, 3});
    chk("full_col_player", 32'(current_player), 32'd1);
    play_move(4);
    chk("after_reject_ref", 32'(st_h[4]), 32'd1);

    do_reset(1'b0);
    play_list('{0, 3, 1, 0, 2, 2, 1, 1, 0, 0});
    chk("diag2_winner", 32'(winner), 32'd2);
    poke_after_over(2'b10);

    do_reset(1'b0);
    for (int rep = 0; rep < 4; rep++) begin
      for (int pr = 0; pr < 4; pr++) begin
        if (pr % 2 == 0) draw_seq = '{2*pr, 2*pr, 2*pr+1, 2*pr+1};
        else             draw_seq = '{2*pr, 2*pr+1, 2*pr+1, 2*pr};
        play_list(draw_seq);
      end
    end
    chk("draw_winner", 32'(winner), 32'd3);
    chk("draw_over", 32'(game_over), 32'd1);

    do_reset(1'b0);
    play_move(2);
`ifdef MOVE_TIMEOUT_EN
    n = 0;
    while (!game_over && n < 2 * TIMEOUT_CYCLES) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", 32'(n), 32'(TIMEOUT_CYCLES));
    chk("timeout_winner", 32'(winner), 32'd1);
    chk("timeout_over", 32'(game_over), 32'd1);
`else
    n = 0;
    repeat (3 * TIMEOUT_CYCLES) begin
      @(negedge clk);
      if (!move_ready || game_over) n++;
    end
    chk("idle_no_timeout", 32'(n), 32'd0);
    play_move(3);
`endif

    for (int g = 0; g < 3; g++) begin
      do_reset(1'b0);
      n = 0;
      while (!ref_over && n < 120) begin
        play_move(int'($urandom_range(0, 7)));
        n++;
      end
      if (ref_over) poke_after_over(ref_winner);
    end

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
